// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO and launch sequencer placed directly in front of a UART transmit
//   port. Producers write bytes in bursts. The sequencer hands the bytes to the
//   UART one at a time and watches the UART busy signal, so producers never
//   have to poll it.
//
//   Optional feature macro: UART_TX_FIFO_OVF_EN
//     When defined, out_overflow becomes a sticky flag. It sets on a write that
//     is dropped because the FIFO is full, and on a busy-wait timeout. It clears
//     on a rising edge of in_ovf_clear. If a set and a clear land in the same
//     cycle, the set wins.
//     When not defined, out_overflow is tied to 0 and in_ovf_clear is ignored.
//
// Parameters
//   DEPTH_LOG2  FIFO depth is 2**DEPTH_LOG2 bytes
//   BUSY_TO     maximum number of cycles to wait for busy to rise after a launch;
//               0 means wait forever
//
// Ports
//   clk, rst_n       clock and asynchronous active-low reset
//   in_wr_en         producer write strobe, one byte per cycle
//   in_wr_data       producer byte
//   out_full         FIFO holds DEPTH bytes
//   out_empty        FIFO holds 0 bytes
//   out_count        number of bytes currently stored
//   out_idle         FIFO empty and sequencer in IDLE
//   out_uart_data    to the UART transmit data input; held from one pop to the next
//   out_uart_valid   to the UART transmit valid input; single-cycle pulse
//   in_uart_busy     from the UART busy output
//   in_ovf_clear     clears out_overflow on its rising edge (feature builds only)
//   out_overflow     sticky overflow flag (feature builds only, otherwise 0)
//
// Sequencer states
//   state       | meaning
//   S_IDLE      | waiting for a stored byte and a UART that is not busy; the pop happens here
//   S_LOAD      | out_uart_valid is high for this one cycle; the timeout counter is loaded
//   S_WAIT_BUSY | waiting for the UART to raise busy; the counter runs down toward the timeout
//   S_WAIT_DONE | UART frame in progress; leave when busy falls

module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int BUSY_TO    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_wr_en,
  input  logic [7:0]            in_wr_data,
  output logic                  out_full,
  output logic                  out_empty,
  output logic [DEPTH_LOG2:0]   out_count,
  output logic                  out_idle,
  output logic [7:0]            out_uart_data,
  output logic                  out_uart_valid,
  input  logic                  in_uart_busy,
  input  logic                  in_ovf_clear,
  output logic                  out_overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TO_W  = (BUSY_TO > 0) ? $clog2(BUSY_TO + 1) : 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [TO_W-1:0]     TO_LOAD = TO_W'(BUSY_TO);
  localparam logic [TO_W-1:0]     TO_ONE  = TO_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic                  full_q, empty_q;
  logic [7:0]            data_q;
  logic [TO_W-1:0]       to_cnt;
  logic                  wr_acc, pop, timeout;

  // Fullness is judged on the registered flag. A write that arrives in the
  // same cycle as a pop from a full FIFO is therefore still dropped.
  assign wr_acc = in_wr_en && !full_q;
  assign pop    = (state_q == S_IDLE) && !empty_q && !in_uart_busy;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= in_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      data_q  <= 8'h00;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr   <= rptr + 1'b1;
        data_q <= mem[rptr];
      end
      count   <= count_nxt;
      full_q  <= (count_nxt == DEPTH_C);
      empty_q <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (in_uart_busy) begin
          state_d = S_WAIT_DONE;
        end else if ((BUSY_TO != 0) && (to_cnt == TO_ONE)) begin
          // The UART never took the byte; abandon it and move on.
          state_d = S_IDLE;
          timeout = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!in_uart_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Down-counter loaded with BUSY_TO in LOAD. It reaches its terminal count
  // after BUSY_TO cycles in WAIT_BUSY and saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state_q == S_LOAD) begin
      to_cnt <= TO_LOAD;
    end else if ((state_q == S_WAIT_BUSY) && (to_cnt != '0)) begin
      to_cnt <= to_cnt - 1'b1;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_clr_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_clr_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_clr_q <= in_ovf_clear;
      if ((in_wr_en && full_q) || timeout) ovf_q <= 1'b1;
      else if (in_ovf_clear && !ovf_clr_q) ovf_q <= 1'b0;
    end
  end

  assign out_overflow = ovf_q;
`else
  logic unused_ovf_sigs;
  assign unused_ovf_sigs = in_ovf_clear ^ timeout;
  assign out_overflow    = 1'b0;
`endif

  assign out_full       = full_q;
  assign out_empty      = empty_q;
  assign out_count      = count;
  assign out_idle       = empty_q && (state_q == S_IDLE);
  assign out_uart_data  = data_q;
  assign out_uart_valid = (state_q == S_LOAD);

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int DEPTH_LOG2 = 4;
  localparam int BUSY_TO    = 64;
  localparam int DEPTH      = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_wr_en;
  logic [7:0]          in_wr_data;
  logic                out_full, out_empty, out_idle;
  logic [DEPTH_LOG2:0] out_count;
  logic [7:0]          out_uart_data;
  logic                out_uart_valid;
  logic                uart_busy = 1'b0;
  logic                in_ovf_clear;
  logic                out_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .BUSY_TO(BUSY_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_wr_en(in_wr_en), .in_wr_data(in_wr_data),
    .out_full(out_full), .out_empty(out_empty), .out_count(out_count),
    .out_idle(out_idle), .out_uart_data(out_uart_data),
    .out_uart_valid(out_uart_valid), .in_uart_busy(uart_busy),
    .in_ovf_clear(in_ovf_clear), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

`ifdef UART_TX_FIFO_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  // UART model and launch monitor, evaluated on the falling edge
  int         busy_len   = 5;
  bit         stuck_zero = 1'b0;
  bit         hold_high  = 1'b0;
  int         busy_rem   = 0;
  logic [7:0] sent_q[$];
  int         sent_cyc[$];
  int         pulse_cnt = 0;
  int         viol      = 0;
  int         max_cnt   = 0;

  always @(negedge clk) begin
    if (int'(out_count) > max_cnt) max_cnt = int'(out_count);
    if (out_uart_valid) begin
      if (uart_busy) viol++;
      sent_q.push_back(out_uart_data);
      sent_cyc.push_back(cyc);
      pulse_cnt++;
      if (!stuck_zero) begin
        busy_rem  = busy_len;
        uart_busy = 1'b1;
      end
    end else if (hold_high) begin
      uart_busy = 1'b1;
    end else if (busy_rem > 0) begin
      busy_rem--;
      if (busy_rem == 0) uart_busy = 1'b0;
    end else begin
      uart_busy = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write_byte(input logic [7:0] d);
    in_wr_en   = 1'b1;
    in_wr_data = d;
    tick();
    in_wr_en = 1'b0;
  endtask

  task automatic clear_mon();
    sent_q.delete();
    sent_cyc.delete();
    pulse_cnt = 0;
    viol      = 0;
    max_cnt   = int'(out_count);
  endtask

  task automatic wait_drain(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (!(pulse_cnt >= n && out_idle && !uart_busy) && k < budget) begin
      tick();
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s_drain: timed out with pulses=%0d idle=%0b, expected %0d pulses and idle",
               name, pulse_cnt, out_idle, n);
    end
  endtask

  task automatic test_reset();
    int p0;
    rst_n = 1'b0; in_wr_en = 1'b0; in_wr_data = 8'h00; in_ovf_clear = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({out_count, out_empty, out_full, out_idle, out_uart_valid, out_uart_data, out_overflow}
        !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_init: cnt=%0d empty=%0b full=%0b idle=%0b valid=%0b data=%h ovf=%0b",
               out_count, out_empty, out_full, out_idle, out_uart_valid, out_uart_data, out_overflow);
    end
    busy_len = 30;
    clear_mon();
    write_byte(8'h3C);
    write_byte(8'h3D);
    write_byte(8'h3E);
    repeat (3) tick();
    n_checks++;
    if (out_uart_data !== 8'h3C || out_count !== 5'd2) begin
      n_fail++;
      $display("FAIL reset_pre: data=%h cnt=%0d, expected data=3c cnt=2", out_uart_data, out_count);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_count, out_empty, out_full, out_idle, out_uart_valid, out_uart_data, out_overflow}
        !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async: cnt=%0d empty=%0b full=%0b idle=%0b valid=%0b data=%h ovf=%0b",
               out_count, out_empty, out_full, out_idle, out_uart_valid, out_uart_data, out_overflow);
    end
    tick();
    tick();
    rst_n = 1'b1;
    p0 = pulse_cnt;
    repeat (50) tick();
    n_checks++;
    if (pulse_cnt !== p0 || out_count !== 5'd0 || out_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_after: pulses=%0d cnt=%0d idle=%0b, expected pulses=%0d cnt=0 idle=1",
               pulse_cnt, out_count, out_idle, p0);
    end
  endtask

  task automatic test_single();
    int wcyc;
    busy_len = 5;
    wait_drain(0, 100, "single_pre");
    clear_mon();
    write_byte(8'hA5);
    wcyc = cyc;
    wait_drain(1, 100, "single");
    n_checks++;
    if (pulse_cnt !== 1 || sent_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_pulses: got %0d pulses, expected 1", pulse_cnt);
    end else begin
      n_checks++;
      if (sent_q[0] !== 8'hA5) begin
        n_fail++;
        $display("FAIL single_data: got %h, expected a5", sent_q[0]);
      end
      n_checks++;
      if (sent_cyc[0] - wcyc != 1) begin
        n_fail++;
        $display("FAIL single_latency: valid %0d cycles after write edge, expected 1", sent_cyc[0] - wcyc);
      end
    end
    n_checks++;
    if (out_idle !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle: got %0b, expected 1", out_idle);
    end
  endtask

  task automatic test_burst();
    bit full_seen;
    busy_len  = 100;
    clear_mon();
    full_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      write_byte(8'(i));
      if (out_full) full_seen = 1'b1;
    end
    n_checks++;
    if (full_seen || out_count !== 5'd15) begin
      n_fail++;
      $display("FAIL burst_fill: full_seen=%0b cnt=%0d, expected full_seen=0 cnt=15", full_seen, out_count);
    end
    wait_drain(16, 2500, "burst");
    n_checks++;
    if (pulse_cnt !== 16 || viol !== 0) begin
      n_fail++;
      $display("FAIL burst_pulses: pulses=%0d busy_overlap=%0d, expected 16 and 0", pulse_cnt, viol);
    end
    for (int i = 0; i < 16 && i < sent_q.size(); i++) begin
      n_checks++;
      if (sent_q[i] !== 8'(i)) begin
        n_fail++;
        $display("FAIL burst_order[%0d]: got %h, expected %h", i, sent_q[i], 8'(i));
      end
    end
  endtask

  task automatic test_overflow();
    busy_len  = 3;
    clear_mon();
    hold_high = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) write_byte(8'h10 + 8'(i));
    n_checks++;
    if (out_count !== 5'd16 || out_full !== 1'b1 || out_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full: cnt=%0d full=%0b empty=%0b, expected 16 1 0", out_count, out_full, out_empty);
    end
    write_byte(8'hEE);
    n_checks++;
    if (out_count !== 5'd16 || out_full !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop: cnt=%0d full=%0b, expected 16 1", out_count, out_full);
    end
    // Release busy and write in the same cycle as the first pop.
    hold_high  = 1'b0;
    in_wr_en   = 1'b1;
    in_wr_data = 8'hEE;
    tick();
    in_wr_en = 1'b0;
    n_checks++;
    if (out_count !== 5'd15 || out_full !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pop_drop: cnt=%0d full=%0b, expected 15 0", out_count, out_full);
    end
    wait_drain(16, 500, "ovf");
    n_checks++;
    if (pulse_cnt !== 16 || max_cnt > DEPTH) begin
      n_fail++;
      $display("FAIL ovf_pulses: pulses=%0d max_cnt=%0d, expected 16 and <=16", pulse_cnt, max_cnt);
    end
    for (int i = 0; i < 16 && i < sent_q.size(); i++) begin
      n_checks++;
      if (sent_q[i] !== 8'h10 + 8'(i)) begin
        n_fail++;
        $display("FAIL ovf_order[%0d]: got %h, expected %h", i, sent_q[i], 8'h10 + 8'(i));
      end
    end
    n_checks++;
    if (out_overflow !== OVF_EXP) begin
      n_fail++;
      $display("FAIL ovf_flag: got %0b, expected %0b", out_overflow, OVF_EXP);
    end
    in_ovf_clear = 1'b1;
    tick();
    in_ovf_clear = 1'b0;
    tick();
    n_checks++;
    if (out_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %0b, expected 0", out_overflow);
    end
  endtask

  task automatic test_timeout();
    int gap;
    clear_mon();
    stuck_zero = 1'b1;
    write_byte(8'h5A);
    write_byte(8'h5B);
    wait_drain(2, 400, "timeout");
    n_checks++;
    if (sent_q.size() != 2) begin
      n_fail++;
      $display("FAIL timeout_pulses: got %0d, expected 2", sent_q.size());
    end else begin
      gap = sent_cyc[1] - sent_cyc[0];
      n_checks++;
      if (sent_q[0] !== 8'h5A || sent_q[1] !== 8'h5B) begin
        n_fail++;
        $display("FAIL timeout_data: got %h %h, expected 5a 5b", sent_q[0], sent_q[1]);
      end
      n_checks++;
      if (gap < 64 || gap > 68) begin
        n_fail++;
        $display("FAIL timeout_gap: got %0d cycles between launches, expected 64..68", gap);
      end
    end
    n_checks++;
    if (out_overflow !== OVF_EXP) begin
      n_fail++;
      $display("FAIL timeout_ovf: got %0b, expected %0b", out_overflow, OVF_EXP);
    end
    stuck_zero   = 1'b0;
    in_ovf_clear = 1'b1;
    tick();
    in_ovf_clear = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    busy_len = 2;
    clear_mon();
    for (int b = 0; b < 40; b++) begin
      write_byte(8'(b * 7 + 3));
      if (b % 6 == 5) repeat (10) tick();
    end
    wait_drain(40, 800, "wrap");
    n_checks++;
    if (pulse_cnt !== 40 || max_cnt > DEPTH) begin
      n_fail++;
      $display("FAIL wrap_pulses: pulses=%0d max_cnt=%0d, expected 40 and <=16", pulse_cnt, max_cnt);
    end
    for (int i = 0; i < 40 && i < sent_q.size(); i++) begin
      n_checks++;
      if (sent_q[i] !== 8'(i * 7 + 3)) begin
        n_fail++;
        $display("FAIL wrap_order[%0d]: got %h, expected %h", i, sent_q[i], 8'(i * 7 + 3));
      end
    end
    n_checks++;
    if (out_count !== 5'd0 || out_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_end: cnt=%0d empty=%0b, expected 0 1", out_count, out_empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
